// File: rtl/decode_regfile_pkg.sv
// Shared constants and types for the MIPS decode / register-file stage.
package decode_regfile_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;

   localparam logic [5:0] FUNCT_JR = 6'h08;

   localparam int OP_LO    = 26;
   localparam int RS_LO    = 21;
   localparam int RT_LO    = 16;
   localparam int RD_LO    = 11;
   localparam int FUNCT_LO = 0;
   localparam int IMM_LO   = 0;
   localparam int IMM_W    = 16;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_ALU_I,
      CLS_STORE,
      CLS_BEQ,
      CLS_BNE,
      CLS_NONE
   } ins_cls_t;

   function automatic ins_cls_t classify(input logic [5:0] op);
      ins_cls_t c;
      c = CLS_NONE;
      case (op)
         OP_RTYPE: c = CLS_R;
         OP_ADDI, OP_ADDIU, OP_SLTI,
         OP_ANDI, OP_ORI, OP_LW: c = CLS_ALU_I;
         OP_SW:  c = CLS_STORE;
         OP_BEQ: c = CLS_BEQ;
         OP_BNE: c = CLS_BNE;
         default: c = CLS_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/decode_regfile_reg_file_2r1w.sv
// Two-read one-write register file with async clear; index 0 is hardwired to zero.
module reg_file_2r1w
   import decode_regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra0,
   input  logic [ADDR_W-1:0] ra1,
   output logic [DATA_W-1:0] rd0,
   output logic [DATA_W-1:0] rd1
);

   localparam int N = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   // No write-through: reads see only committed contents.
   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];

endmodule

// File: rtl/decode_regfile.sv
// Decode stage: field decode, immediate extension, register read and branch compare.
module decode_regfile
   import decode_regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instruction,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] imm_ext,
   output logic [ADDR_W-1:0] dest_addr,
   output logic              reg_write,
   output logic              npc_sel
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [ADDR_W-1:0] rs_idx;
   logic [ADDR_W-1:0] rt_idx;
   logic [ADDR_W-1:0] rd_idx;
   logic [IMM_W-1:0]  imm;
   ins_cls_t          cls;
   logic              run;
   logic              rw_dec;
   logic              taken;
   logic              unused_shamt;

   assign opcode = instruction[OP_LO +: 6];
   assign funct  = instruction[FUNCT_LO +: 6];
   assign rs_idx = instruction[RS_LO +: ADDR_W];
   assign rt_idx = instruction[RT_LO +: ADDR_W];
   assign rd_idx = instruction[RD_LO +: ADDR_W];
   assign imm    = instruction[IMM_LO +: IMM_W];
   assign cls    = classify(opcode);

   assign unused_shamt = ^instruction[10:6];

   reg_file_2r1w #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wb_en),
      .wa    (wb_addr),
      .wd    (wb_data),
      .ra0   (rs_idx),
      .ra1   (rt_idx),
      .rd0   (rs_data),
      .rd1   (rt_data)
   );

   // Release of reset becomes visible only at the first clock edge after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run <= 1'b0;
      else        run <= 1'b1;
   end

   always_comb begin
      rw_dec    = 1'b0;
      dest_addr = '0;
      taken     = 1'b0;
      unique case (cls)
         CLS_R: begin
            dest_addr = rd_idx;
            rw_dec    = (funct != FUNCT_JR);
         end
         CLS_ALU_I: begin
            dest_addr = rt_idx;
            rw_dec    = 1'b1;
         end
         CLS_STORE: dest_addr = rt_idx;
         CLS_BEQ: begin
            dest_addr = rt_idx;
            taken     = (rs_data == rt_data);
         end
         CLS_BNE: begin
            dest_addr = rt_idx;
            taken     = (rs_data != rt_data);
         end
         default: ;
      endcase
   end

   always_comb begin
      imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      if (opcode == OP_ANDI || opcode == OP_ORI)
         imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
   end

   assign reg_write = run & rw_dec;
   assign npc_sel   = run & taken;

endmodule
